muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 16 bits, iteration count fixed at 16.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  in  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port: op  in  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-006 SHALL have ports: a  in  16  multiplicand/dividend; b  in  16  multiplier/divisor; both captured on the accepted start.
REQ-007 SHALL have ports: busy  out  1; done  out  1  single-cycle completion pulse.
REQ-008 SHALL have ports: res_lo  out  16  product low half or quotient; res_hi  out  16  remainder (0 for multiply).
REQ-009 SHALL have port: div_zero  out  1  set with done when a divide has b = 0.
REQ-010 SHALL have ports: alu_op1  out  16; alu_op2  out  16; alu_cmd  out  3  drive to the shared combinational ALU.
REQ-011 SHALL have port: alu_res  in  16  ALU result, valid in the same cycle.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE, with a 4-bit iteration counter.
REQ-013 Transitions: IDLE->MUL on start & op=0; IDLE->DIV on start & op=1 & b!=0; IDLE->DONE on start & op=1 & b=0; MUL/DIV->DONE after iteration 15; DONE->IDLE unconditionally.
REQ-014 SHALL start the counter at 0 on entry to MUL/DIV and perform exactly one iteration per cycle; latency start-edge T -> done at T+17; divide-by-zero -> done at T+1.
REQ-015 busy SHALL be 1 in MUL, DIV and DONE, and 0 in IDLE; start while busy SHALL be ignored with no effect on state or captured operands.
REQ-016 done SHALL be 1 only in DONE, for exactly one cycle.
REQ-017 MUL iteration: alu_cmd=000 (add), alu_op1=acc, alu_op2=mcand; if mplier[0]=1, acc<=alu_res, else acc unchanged; then mcand<<=1 and mplier>>=1 (locally, zero fill).
REQ-018 MUL SHALL yield the low 16 bits of a*b in res_lo (modulo 2^16); res_hi=0; ALU overflow is ignored.
REQ-019 DIV iteration (restoring): rs = {rem,quo[15]} (17 bits), quo<<=1; alu_cmd=001 (sub), alu_op1=rs[15:0], alu_op2=b_reg; if rs >= {0,b_reg} (local 17-bit unsigned compare), rem<=alu_res and quo[0]<=1, else rem<=rs[15:0] and quo[0]<=0.
REQ-020 DIV SHALL yield res_lo = a/b and res_hi = a mod b (unsigned).
REQ-021 Divide by zero SHALL yield res_lo=16'hFFFF, res_hi=a, and div_zero=1; no ALU iterations SHALL be performed.
REQ-022 In IDLE and DONE, alu_cmd SHALL be 000, and alu_op1/alu_op2 SHALL be 0.
REQ-023 res_lo, res_hi and div_zero SHALL update on the edge entering DONE and hold until the next accepted start; div_zero SHALL clear on an accepted start.
REQ-024 alu_op1, alu_op2 and alu_cmd SHALL be combinational from state and registers only, never from the start/a/b inputs.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, counter=0, and all internal registers to 0, including mid-operation; the in-flight result is discarded.
REQ-026 After reset, busy, done, div_zero, res_lo, res_hi, alu_op1 and alu_op2 SHALL be 0, and alu_cmd SHALL be 000.
REQ-027 rst SHALL take priority over start in the same cycle.

Verification
REQ-028 Multiply: start, op=0, a=7, b=6 -> done at T+17, res_lo=42, res_hi=0, div_zero=0.
REQ-029 Multiply wrap: a=16'hFFFF, b=16'hFFFF -> res_lo=16'h0001, res_hi=0.
REQ-030 Divide: op=1, a=100, b=7 -> done at T+17, res_lo=14, res_hi=2; also a=16'hFFFF, b=1 -> res_lo=16'hFFFF, res_hi=0.
REQ-031 Divide by zero: op=1, a=16'h1234, b=0 -> done at T+1, res_lo=16'hFFFF, res_hi=16'h1234, div_zero=1, busy=1 for one cycle only.
REQ-032 Busy/reset: start a divide, pulse start with new a/b at T+5 -> ignored, original result at T+17; separately assert rst at T+8 -> next cycle IDLE, all outputs 0, no done pulse.

Source files
------------

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq -- sequential 16x16 unsigned multiply / divide engine that
// borrows an external combinational ALU for its per-iteration add/subtract.
//
// Ports:
//   clk       in   1   clock, all state updates on the rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   request pulse, only looked at while idle
//   op        in   1   0 = multiply, 1 = divide
//   a, b      in  16   multiplicand/dividend, multiplier/divisor
//   busy      out  1   engine occupied (MUL, DIV or DONE)
//   done      out  1   one-cycle completion pulse
//   res_lo    out 16   product low half / quotient
//   res_hi    out 16   remainder (0 for multiply)
//   div_zero  out  1   last divide had a zero divisor
//   alu_op1   out 16   operands and command to the shared ALU
//   alu_op2   out 16
//   alu_cmd   out  3   000 = add, 001 = subtract
//   alu_res   in  16   ALU result, valid in the same cycle
// ---------------------------------------------------------------------------
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_lo,
  output logic [15:0] res_hi,
  output logic        div_zero,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic [2:0]  alu_cmd,
  input  logic [15:0] alu_res
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // Shared working registers:
  //   MUL: acc = running product, opa = shifted multiplicand, opb = multiplier
  //   DIV: acc = partial remainder, opa = dividend/quotient shift register,
  //        opb = divisor
  logic [15:0] acc_q, acc_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] res_lo_q, res_lo_d;
  logic [15:0] res_hi_q, res_hi_d;
  logic        dz_q, dz_d;

  logic [16:0] rs;
  logic        rs_ge;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dz_d     = dz_q;
    alu_op1  = 16'd0;
    alu_op2  = 16'd0;
    alu_cmd  = 3'b000;
    // Shifted remainder: next dividend bit enters from the quotient MSB.
    rs       = {acc_q, opa_q[15]};
    rs_ge    = (rs >= {1'b0, opb_q});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = 16'd0;
          opa_d = a;
          opb_d = b;
          cnt_d = 4'd0;
          dz_d  = 1'b0;
          if (!op) begin
            state_d = S_MUL;
          end else if (b != 16'd0) begin
            state_d = S_DIV;
          end else begin
            // Zero divisor: finish immediately without touching the ALU.
            state_d  = S_DONE;
            res_lo_d = 16'hFFFF;
            res_hi_d = a;
            dz_d     = 1'b1;
          end
        end
      end

      S_MUL: begin
        alu_cmd = 3'b000;
        alu_op1 = acc_q;
        alu_op2 = opa_q;
        if (opb_q[0]) begin
          acc_d = alu_res;
        end
        opa_d = {opa_q[14:0], 1'b0};
        opb_d = {1'b0, opb_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d  = S_DONE;
          res_lo_d = acc_d;
          res_hi_d = 16'd0;
        end
      end

      S_DIV: begin
        alu_cmd = 3'b001;
        alu_op1 = rs[15:0];
        alu_op2 = opb_q;
        // When rs[16] is set the true difference is still below the divisor,
        // so the 16-bit ALU result is exact.
        if (rs_ge) begin
          acc_d = alu_res;
          opa_d = {opa_q[14:0], 1'b1};
        end else begin
          acc_d = rs[15:0];
          opa_d = {opa_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d  = S_DONE;
          res_lo_d = opa_d;
          res_hi_d = acc_d;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      acc_q    <= 16'd0;
      opa_q    <= 16'd0;
      opb_q    <= 16'd0;
      res_lo_q <= 16'd0;
      res_hi_q <= 16'd0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign res_lo   = res_lo_q;
  assign res_hi   = res_hi_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq -- scoreboard bench for muldiv_seq. Expected results (value
// and the clock edge at which done must be sampled) are queued when a start
// is driven and compared when done appears. A behavioural add/sub ALU is
// attached to the ALU ports.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [15:0] a, b;
  logic        busy, done, div_zero;
  logic [15:0] res_lo, res_hi, alu_op1, alu_op2, alu_res;
  logic [2:0]  alu_cmd;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];

  muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .res_lo   (res_lo),
    .res_hi   (res_hi),
    .div_zero (div_zero),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_cmd  (alu_cmd),
    .alu_res  (alu_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External shared ALU.
  always_comb begin
    alu_res = 16'd0;
    case (alu_cmd)
      3'b000:  alu_res = alu_op1 + alu_op2;
      3'b001:  alu_res = alu_op1 - alu_op2;
      default: alu_res = 16'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Done monitor: sampled on the falling edge; done is captured by the next
  // rising edge, numbered cyc+1.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn done@%0d lo=%h hi=%h dz=%0d", cyc + 1, res_lo, res_hi, div_zero);
        chk("res_lo", {16'd0, res_lo}, {16'd0, e.lo});
        chk("res_hi", {16'd0, res_hi}, {16'd0, e.hi});
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        chk("latency", cyc + 1, e.due);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic push_exp(input logic o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    logic [31:0] p;
    p = x * y;
    if (!o) begin
      e.lo = p[15:0]; e.hi = 16'd0; e.dz = 1'b0; e.due = cyc + 1 + 17;
    end else if (y == 16'd0) begin
      e.lo = 16'hFFFF; e.hi = x; e.dz = 1'b1; e.due = cyc + 1 + 1;
    end else begin
      e.lo = x / y; e.hi = x % y; e.dz = 1'b0; e.due = cyc + 1 + 17;
    end
    sb.push_back(e);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    push_exp(o, x, y);
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    chk("alu_cmd_run", {29'd0, alu_cmd}, (o && y != 16'd0) ? 32'd1 : 32'd0);
    wait_empty();
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_alu_op1", {16'd0, alu_op1}, 32'd0);
  endtask

  initial begin
    int e0;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = 16'd0; b = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res_lo", {16'd0, res_lo}, 32'd0);
    chk("rst_alu_op2", {16'd0, alu_op2}, 32'd0);
    rst = 1'b0;

    do_op(1'b0, 16'd7, 16'd6);
    do_op(1'b0, 16'hFFFF, 16'hFFFF);
    do_op(1'b1, 16'd100, 16'd7);
    do_op(1'b1, 16'hFFFF, 16'd1);
    do_op(1'b1, 16'h1234, 16'd0);
    for (int i = 0; i < 6; i++) begin
      do_op(i[0], 16'($urandom), 16'($urandom_range(1, 65535)));
    end

    // Start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 16'd100; b = 16'd7;
    e0 = cyc + 1;
    push_exp(1'b1, 16'd100, 16'd7);
    @(negedge clk);
    start = 1'b0;
    while (cyc != e0 + 4) @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'd5; b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    @(negedge clk);

    // Reset mid-divide: rst sampled at the 8th edge after the accept edge.
    start = 1'b1; op = 1'b1; a = 16'd1000; b = 16'd3;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc != e0 + 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_res_lo", {16'd0, res_lo}, 32'd0);
    chk("mid_rst_res_hi", {16'd0, res_hi}, 32'd0);
    chk("mid_rst_alu_cmd", {29'd0, alu_cmd}, 32'd0);
    chk("mid_rst_alu_op1", {16'd0, alu_op1}, 32'd0);
    repeat (25) @(negedge clk);

    // Reset has priority over a simultaneous start.
    rst = 1'b1; start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
